// File: rtl/ddr2pe_ab_pkg.sv
// Shared widths, FSM state type and sizing helper for the DDR-to-PE buffer loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package GLOBAL_PARAM;

    localparam int DDR_W  = 64;
    localparam int DATA_W = 16;
    localparam int TAIL_W = 32;
    localparam int RES_W  = 32;
    localparam int BATCH  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } ddr2pe_state_t;

    // Bits needed to index n entries (never less than one bit).
    function automatic int bw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ddr2pe_unpack.sv
// Holds one DDR word and hands out its data or tail elements LSB-first, one per emit.
// Latency: element visible combinationally from the hold register; load takes one edge.
// Backpressure: parent decides emit/load; a load always wins over an emit in the same cycle.
module ddr2pe_unpack
    import GLOBAL_PARAM::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              tail_mode,
    input  logic              load,
    input  logic [DDR_W-1:0]  word,
    input  logic              emit,
    input  logic              last,
    output logic              held,
    output logic              slot_last,
    output logic [7:0]        held_rem,
    output logic [DATA_W-1:0] data_elem,
    output logic [TAIL_W-1:0] tail_elem
);

    localparam int DPACK   = DDR_W / DATA_W;
    localparam int TPACK   = DDR_W / TAIL_W;
    localparam int MAXPACK = (DPACK > TPACK) ? DPACK : TPACK;
    localparam int SLOT_W  = bw(MAXPACK);

    logic [DDR_W-1:0]  hold;
    logic [SLOT_W-1:0] slot;
    logic [SLOT_W-1:0] pack_m1;

    // Slot limit and remaining-element count for the active field type.
    always_comb begin
        pack_m1   = tail_mode ? SLOT_W'(TPACK - 1) : SLOT_W'(DPACK - 1);
        slot_last = held && (slot == pack_m1);
        held_rem  = held ? (8'(pack_m1) - 8'(slot) + 8'd1) : 8'd0;
        data_elem = hold[slot*DATA_W +: DATA_W];
        tail_elem = hold[slot*TAIL_W +: TAIL_W];
    end

    // Hold register and slot pointer: a new word restarts at slot 0, the last emit empties it.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hold <= '0;
            held <= 1'b0;
            slot <= '0;
        end else if (load) begin
            hold <= word;
            held <= 1'b1;
            slot <= '0;
        end else if (emit) begin
            if (last) begin
                held <= 1'b0;
                slot <= '0;
            end else begin
                slot <= slot + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr2pe_ab.sv
// Streams DDR words into abuf (whole words) or bbuf (unpacked data/tail elements).
// Latency: each write appears on its port one cycle after the accept or unpack that caused it.
// Backpressure: ddr1_ready only while more entries are needed; bbuf refills with no bubble.
module ddr2pe_ab
    import GLOBAL_PARAM::*;
#(
    parameter int BUF_DEPTH = 256,
    parameter int ADDR_W    = bw(BUF_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              done,
    input  logic [1:0]        conf_trans_type,
    input  logic [7:0]        conf_trans_num,
    input  logic [DDR_W-1:0]  ddr1_data,
    input  logic              ddr1_valid,
    output logic              ddr1_ready,
    output logic [ADDR_W-1:0] abuf_wr_addr,
    output logic [DDR_W-1:0]  abuf_wr_data,
    output logic              abuf_wr_en,
    output logic [ADDR_W-1:0] bbuf_wr_addr,
    output logic [DATA_W-1:0] bbuf_wr_data,
    output logic              bbuf_wr_data_en,
    output logic [TAIL_W-1:0] bbuf_wr_tail,
    output logic              bbuf_wr_tail_en
);

    ddr2pe_state_t state;

    logic [1:0] cfg_type;
    logic [7:0] cfg_num;
    logic [7:0] wr_cnt;

    logic bmode;
    logic tail_mode;
    logic in_recv;
    logic [7:0] rem;
    logic emit;
    logic elem_last;
    logic accept;
    logic ready_c;

    logic              held;
    logic              slot_last;
    logic [7:0]        held_rem;
    logic [DATA_W-1:0] data_elem;
    logic [TAIL_W-1:0] tail_elem;

    // Handshake and unpack decisions derived from the registered state and counters.
    always_comb begin
        bmode     = cfg_type[1];
        tail_mode = (cfg_type == 2'b11);
        in_recv   = (state == RECV);
        rem       = cfg_num - wr_cnt;
        emit      = in_recv && bmode && held && (wr_cnt != cfg_num);
        elem_last = emit && (slot_last || (wr_cnt == cfg_num - 8'd1));
        ready_c   = 1'b0;
        if (in_recv && !start) begin
            if (bmode)
                ready_c = (rem > held_rem) && (!held || slot_last);
            else
                ready_c = (wr_cnt != cfg_num);
        end
        accept     = ready_c && ddr1_valid;
        ddr1_ready = ready_c;
    end

    ddr2pe_unpack u_unpack (
        .clk       (clk),
        .rst       (rst),
        .clr       (start),
        .tail_mode (tail_mode),
        .load      (accept && bmode),
        .word      (ddr1_data),
        .emit      (emit),
        .last      (elem_last),
        .held      (held),
        .slot_last (slot_last),
        .held_rem  (held_rem),
        .data_elem (data_elem),
        .tail_elem (tail_elem)
    );

    // Control FSM plus registered write ports; start from any state (re)launches a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            done            <= 1'b0;
            cfg_type        <= 2'b00;
            cfg_num         <= 8'd0;
            wr_cnt          <= 8'd0;
            abuf_wr_en      <= 1'b0;
            abuf_wr_addr    <= '0;
            abuf_wr_data    <= '0;
            bbuf_wr_addr    <= '0;
            bbuf_wr_data    <= '0;
            bbuf_wr_data_en <= 1'b0;
            bbuf_wr_tail    <= '0;
            bbuf_wr_tail_en <= 1'b0;
        end else begin
            abuf_wr_en      <= 1'b0;
            bbuf_wr_data_en <= 1'b0;
            bbuf_wr_tail_en <= 1'b0;
            done            <= 1'b0;
            if (start) begin
                state        <= RECV;
                cfg_type     <= conf_trans_type;
                cfg_num      <= conf_trans_num;
                wr_cnt       <= 8'd0;
                abuf_wr_addr <= '0;
                bbuf_wr_addr <= '0;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    RECV: begin
                        if (wr_cnt == cfg_num) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                        if (accept && !bmode) begin
                            abuf_wr_en   <= 1'b1;
                            abuf_wr_addr <= ADDR_W'(wr_cnt);
                            abuf_wr_data <= ddr1_data;
                            wr_cnt       <= wr_cnt + 8'd1;
                        end
                        if (emit) begin
                            bbuf_wr_addr <= ADDR_W'(wr_cnt);
                            wr_cnt       <= wr_cnt + 8'd1;
                            if (tail_mode) begin
                                bbuf_wr_tail_en <= 1'b1;
                                bbuf_wr_tail    <= tail_elem;
                            end else begin
                                bbuf_wr_data_en <= 1'b1;
                                bbuf_wr_data    <= data_elem;
                            end
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ddr2pe_ab.sv
// Directed, table-driven bench for ddr2pe_ab with hand-computed write counts and timing.
// Latency: checks done/ready timing relative to the start edge.
// Backpressure: words advance only on valid&ready; gaps come from delayed valid.
module tb_ddr2pe_ab;
    import GLOBAL_PARAM::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              done;
    logic [1:0]        conf_trans_type;
    logic [7:0]        conf_trans_num;
    logic [DDR_W-1:0]  ddr1_data;
    logic              ddr1_valid;
    logic              ddr1_ready;
    logic [7:0]        abuf_wr_addr;
    logic [DDR_W-1:0]  abuf_wr_data;
    logic              abuf_wr_en;
    logic [7:0]        bbuf_wr_addr;
    logic [DATA_W-1:0] bbuf_wr_data;
    logic              bbuf_wr_data_en;
    logic [TAIL_W-1:0] bbuf_wr_tail;
    logic              bbuf_wr_tail_en;

    always #5 clk = ~clk;

    ddr2pe_ab dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .done            (done),
        .conf_trans_type (conf_trans_type),
        .conf_trans_num  (conf_trans_num),
        .ddr1_data       (ddr1_data),
        .ddr1_valid      (ddr1_valid),
        .ddr1_ready      (ddr1_ready),
        .abuf_wr_addr    (abuf_wr_addr),
        .abuf_wr_data    (abuf_wr_data),
        .abuf_wr_en      (abuf_wr_en),
        .bbuf_wr_addr    (bbuf_wr_addr),
        .bbuf_wr_data    (bbuf_wr_data),
        .bbuf_wr_data_en (bbuf_wr_data_en),
        .bbuf_wr_tail    (bbuf_wr_tail),
        .bbuf_wr_tail_en (bbuf_wr_tail_en)
    );

    typedef struct {
        logic [1:0] t;
        logic [7:0] n;
        int gap;
        int exp_wr;
        int exp_words;
        int exp_done;
        int exp_ready;
    } vec_t;

    vec_t vt [12];

    int n_cmp = 0;
    int n_bad = 0;
    int widx, base, cyc;
    int nwr_a, nwr_d, nwr_t, nacc, nready, ndone, done_cyc;
    logic accepted;

    // Word i carries its index in every lane's top byte and the lane number below it.
    function automatic logic [63:0] w(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {b, 8'h04, b, 8'h03, b, 8'h02, b, 8'h01};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        nwr_a = 0; nwr_d = 0; nwr_t = 0; nacc = 0; nready = 0; ndone = 0; done_cyc = -1;
    endtask

    task automatic sample();
        logic [63:0] wd;
        accepted = ddr1_valid && ddr1_ready;
        if (accepted) nacc++;
        if (ddr1_ready) nready++;
        if (abuf_wr_en) begin
            chk("abuf_addr", 64'(abuf_wr_addr), 64'(nwr_a));
            chk("abuf_data", abuf_wr_data, w(base + nwr_a));
            nwr_a++;
        end
        if (bbuf_wr_data_en) begin
            wd = w(base + nwr_d / 4);
            chk("data_addr", 64'(bbuf_wr_addr), 64'(nwr_d));
            chk("data_lane", 64'(bbuf_wr_data), 64'(wd[(nwr_d % 4)*16 +: 16]));
            nwr_d++;
        end
        if (bbuf_wr_tail_en) begin
            wd = w(base + nwr_t / 2);
            chk("tail_addr", 64'(bbuf_wr_addr), 64'(nwr_t));
            chk("tail_lane", 64'(bbuf_wr_tail), 64'(wd[(nwr_t % 2)*32 +: 32]));
            nwr_t++;
        end
        if (done) begin
            ndone++;
            done_cyc = cyc;
        end
    endtask

    task automatic step(input int gap);
        cyc++;
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        if (accepted) widx++;
        ddr1_data  = w(widx);
        ddr1_valid = (cyc + 1 > gap);
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic begin_xfer(input logic [1:0] t, input logic [7:0] n, input int gap);
        conf_trans_type = t;
        conf_trans_num  = n;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        conf_trans_type = 2'b00;
        conf_trans_num  = 8'hFF;
        base = widx;
        cyc  = 0;
        clear_counts();
        ddr1_data  = w(widx);
        ddr1_valid = (1 > gap);
    endtask

    task automatic run_vec(input int i);
        int wrong;
        begin_xfer(vt[i].t, vt[i].n, vt[i].gap);
        repeat (16) step(vt[i].gap);
        if (vt[i].t[1] == 1'b0)      wrong = nwr_d + nwr_t;
        else if (vt[i].t == 2'b10)   wrong = nwr_a + nwr_t;
        else                         wrong = nwr_a + nwr_d;
        $display("vector %0d: type=%b num=%0d", i, vt[i].t, vt[i].n);
        chk("writes",     64'(nwr_a + nwr_d + nwr_t), 64'(vt[i].exp_wr));
        chk("wrong_port", 64'(wrong), 64'd0);
        chk("words",      64'(nacc), 64'(vt[i].exp_words));
        chk("done_count", 64'(ndone), 64'd1);
        chk("done_cycle", 64'(done_cyc), 64'(vt[i].exp_done));
        chk("ready_cyc",  64'(nready), 64'(vt[i].exp_ready));
    endtask

    initial begin
        //          t      n     gap wr words done ready
        vt[0]  = '{2'b00, 8'd3, 0, 3, 3, 5,  3};
        vt[1]  = '{2'b01, 8'd1, 0, 1, 1, 3,  1};
        vt[2]  = '{2'b10, 8'd8, 0, 8, 2, 11, 2};
        vt[3]  = '{2'b11, 8'd3, 0, 3, 2, 6,  2};
        vt[4]  = '{2'b00, 8'd0, 0, 0, 0, 2,  0};
        vt[5]  = '{2'b10, 8'd0, 0, 0, 0, 2,  0};
        vt[6]  = '{2'b10, 8'd5, 0, 5, 2, 8,  2};
        vt[7]  = '{2'b11, 8'd4, 0, 4, 2, 7,  2};
        vt[8]  = '{2'b10, 8'd4, 2, 4, 1, 9,  3};
        vt[9]  = '{2'b00, 8'd2, 1, 2, 2, 5,  3};
        vt[10] = '{2'b00, 8'd2, 0, 2, 2, 4,  2};
        vt[11] = '{2'b10, 8'd4, 0, 4, 1, 7,  1};

        widx = 0; base = 0; cyc = 0; accepted = 1'b0;
        clear_counts();
        rst = 1'b1; start = 1'b0;
        conf_trans_type = 2'b00; conf_trans_num = 8'd0;
        ddr1_data = w(0); ddr1_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 64'(ddr1_ready), 64'd0);
        chk("rst_done",  64'(done), 64'd0);
        chk("rst_wr_en", 64'({abuf_wr_en, bbuf_wr_data_en, bbuf_wr_tail_en}), 64'd0);
        chk("rst_addr",  64'({abuf_wr_addr, bbuf_wr_addr}), 64'd0);

        for (int i = 0; i < 10; i++) run_vec(i);

        // Abort: a second start mid-transfer restarts cleanly; only the new transfer reports done.
        begin_xfer(2'b10, 8'd8, 0);
        repeat (3) step(0);
        run_vec(10);

        // Reset during the second word: nothing further is written and done never fires.
        begin_xfer(2'b10, 8'd8, 0);
        repeat (5) step(0);
        rst = 1'b1;
        step(0);
        clear_counts();
        repeat (12) step(0);
        chk("rst_mid_writes", 64'(nwr_a + nwr_d + nwr_t), 64'd0);
        chk("rst_mid_done",   64'(ndone), 64'd0);
        chk("rst_mid_ready",  64'(nready), 64'd0);
        run_vec(11);

        // Reset beats a simultaneous start.
        conf_trans_type = 2'b00; conf_trans_num = 8'd3;
        rst = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        cyc = 0;
        clear_counts();
        repeat (8) step(0);
        chk("rst_pri_ready", 64'(nready), 64'd0);
        chk("rst_pri_done",  64'(ndone), 64'd0);
        chk("rst_pri_wr",    64'(nwr_a + nwr_d + nwr_t), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
